// File: rtl/cnu_sched.sv
// Check-node row scheduler: issues M rows per iteration through a LAT-deep cnu pipeline,
// drains between iterations, and stops on the iteration limit (or zero syndrome with CNU_EARLY_TERM_EN).
module cnu_sched #(
    parameter int M      = 16,
    parameter int LAT    = 2,
    parameter int ITER_W = 4,
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              stall,
    input  logic              par_in,
    output logic              rd_en,
    output logic [ROW_W-1:0]  rd_row,
    output logic              cnu_en,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_row,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CHECK, S_DONE} state_t;

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [ITER_W-1:0] r_nlim;
    logic [ITER_W-1:0] r_iter;
    logic              r_acc;
    logic              r_busy;
    logic              r_done;
    logic              r_conv;
    logic              r_dl_vld [LAT];
    logic [ROW_W-1:0]  r_dl_row [LAT];

    logic              w_issue;
    logic              w_wr;
    logic              w_inner_empty;
    logic [ITER_W-1:0] w_iter_nx;
    logic              w_term;

    assign w_issue   = (r_state == S_RUN) && !stall;
    assign w_wr      = r_dl_vld[LAT-1] && !stall;
    assign w_iter_nx = r_iter + ITER_W'(1);

`ifdef CNU_EARLY_TERM_EN
    assign w_term = (w_iter_nx == r_nlim) || !r_acc;
`else
    assign w_term = (w_iter_nx == r_nlim);
`endif

    // Only the tail may still hold data when DRAIN hands over; it retires on this same cycle.
    always_comb begin
        w_inner_empty = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (r_dl_vld[i]) w_inner_empty = 1'b0;
        end
    end

    // Issue-to-writeback delay line, frozen as a whole while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_dl_vld[i] <= 1'b0;
                r_dl_row[i] <= '0;
            end
        end else if (!stall) begin
            r_dl_vld[0] <= w_issue;
            r_dl_row[0] <= r_row;
            for (int i = 1; i < LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_row[i] <= r_dl_row[i-1];
            end
        end
    end

    // Control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_nlim  <= '0;
            r_iter  <= '0;
            r_acc   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_conv  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr) r_acc <= r_acc | par_in;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nlim  <= (n_iter == '0) ? ITER_W'(1) : n_iter;
                        r_iter  <= '0;
                        r_conv  <= 1'b0;
                        r_row   <= '0;
                        r_acc   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (r_row == ROW_W'(M - 1)) r_state <= S_DRAIN;
                        else                        r_row   <= r_row + ROW_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!stall && w_inner_empty) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_iter <= w_iter_nx;
                    r_conv <= !r_acc;
                    if (w_term) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_row   <= '0;
                        r_acc   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_en     = w_issue;
    assign rd_row    = r_row;
    assign wr_en     = w_wr;
    assign wr_row    = r_dl_row[LAT-1];
    assign cnu_en    = r_busy && !stall;
    assign busy      = r_busy;
    assign done      = r_done;
    assign converged = r_conv;
    assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_cnu_sched.sv
// Bench for cnu_sched (M=4, LAT=2): directed test-plan runs plus randomized stall/parity runs
// checked every cycle against a phase-timeline reference model.
module tb_cnu_sched;

    localparam int M  = 4;
    localparam int LAT = 2;
    localparam int IW = 4;
    localparam int RW = 2;
`ifdef CNU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] n_iter;
    logic          stall;
    logic          par_in;
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic          cnu_en;
    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic          busy;
    logic          done;
    logic          converged;
    logic [IW-1:0] iter_cnt;

    cnu_sched #(.M(M), .LAT(LAT), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .stall(stall), .par_in(par_in),
        .rd_en(rd_en), .rd_row(rd_row), .cnu_en(cnu_en), .wr_en(wr_en), .wr_row(wr_row),
        .busy(busy), .done(done), .converged(converged), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: decode seen as a timeline of un-stalled phases per iteration.
    // Phase p: row p read when p<M, row p-LAT written when LAT<=p<M+LAT, check at p=M+LAT.
    int m_mode;   // 0 idle, 1 iterating, 2 done pulse
    int m_p;
    int m_cnt;
    int m_nlim;
    bit m_acc;
    bit m_conv;
    int cyc;
    int done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_mode = 0; m_p = 0; m_cnt = 0; m_nlim = 1; m_acc = 1'b0; m_conv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; par_in = 1'b0;
        #2;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cnu_en", cnu_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_converged", converged, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_wr_row", wr_row, 0);
        chk("rst_iter_cnt", iter_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, advance the model.
    task automatic step(input bit s, input bit st, input bit p);
        bit e_rd, e_wr, e_busy;
        stall = s; start = st; par_in = p;
        @(negedge clk);
        e_rd   = (m_mode == 1) && (m_p < M) && !s;
        e_wr   = (m_mode == 1) && (m_p >= LAT) && (m_p < M + LAT) && !s;
        e_busy = (m_mode != 0);
        chk("rd_en", rd_en, e_rd);
        chk("wr_en", wr_en, e_wr);
        chk("cnu_en", cnu_en, e_busy && !s);
        chk("busy", busy, e_busy);
        chk("done", done, m_mode == 2);
        chk("converged", converged, m_conv);
        chk("iter_cnt", iter_cnt, m_cnt);
        if (e_rd) chk("rd_row", rd_row, m_p);
        if (e_wr) chk("wr_row", wr_row, m_p - LAT);
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        case (m_mode)
            0: if (st) begin
                m_mode = 1; m_p = 0; m_cnt = 0; m_acc = 1'b0; m_conv = 1'b0;
                m_nlim = (n_iter == 0) ? 1 : int'(n_iter);
            end
            1: if (m_p == M + LAT) begin
                m_cnt++;
                m_conv = !m_acc;
                if (m_cnt == m_nlim || (EARLY && !m_acc)) m_mode = 2;
                else begin m_p = 0; m_acc = 1'b0; end
            end else if (!s) begin
                if (m_p >= LAT) m_acc = m_acc | p;
                m_p++;
            end
            default: m_mode = 0;
        endcase
        cyc++;
        @(posedge clk); #1;
    endtask

    // pmode: 0 parity 0, 1 parity 1, 2 random, 3 parity 1 only in the first iteration
    task automatic run(input int nit, input int stall_pct, input int s_lo, input int s_hi,
                       input int pmode, input int exp_done, input int ign_start);
        bit s, p;
        n_iter = IW'(nit);
        cyc = 0;
        done_cyc = -1;
        step(1'b0, 1'b1, 1'b0);
        while (m_mode != 0 && cyc < 2000) begin
            s = (cyc >= s_lo && cyc <= s_hi) || ($urandom_range(99) < stall_pct);
            case (pmode)
                0: p = 1'b0;
                1: p = 1'b1;
                2: p = 1'($urandom_range(1));
                default: p = (m_cnt == 0);
            endcase
            step(s, cyc == ign_start, p);
        end
        chk("finished_idle", busy, 0);
        if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    endtask

    initial begin
        n_iter = '0;
        model_clear();
        cyc = 0;
        done_cyc = -1;
        do_reset();

        run(1, 0, -1, -1, 0, 8, -1);
        chk("t1_iter_cnt", iter_cnt, 1);
        chk("t1_converged", converged, 1);

        run(3, 0, -1, -1, 1, 22, -1);
        chk("t2_iter_cnt", iter_cnt, 3);
        chk("t2_converged", converged, 0);

        run(5, 0, -1, -1, 3, EARLY ? 15 : 36, -1);
        chk("t3_iter_cnt", iter_cnt, EARLY ? 2 : 5);
        chk("t3_converged", converged, 1);

        run(1, 0, 2, 3, 0, 10, 4);
        chk("t4_iter_cnt", iter_cnt, 1);

        n_iter = IW'(2);
        cyc = 0;
        done_cyc = -1;
        step(1'b0, 1'b1, 1'b0);
        while (m_p < M && cyc < 100) step(1'b0, 1'b0, 1'($urandom_range(1)));
        do_reset();
        run(0, 0, -1, -1, 0, 8, -1);
        chk("t5_iter_cnt", iter_cnt, 1);

        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(4)), 25, -1, -1, 2, -1, int'($urandom_range(10, 1)));
            step(1'b1, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
